// File: rtl/full_feed_pkg.sv
// Shared types for the full_feed training-data feeder.
package full_feed_pkg;

  // 24-bit mantissa / 8-bit exponent float word.
  typedef logic [31:0] float_24_8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFinish
  } full_feed_state_e;

  localparam int unsigned FrameCntW = 16;

endpackage

// File: rtl/full_feed_ram.sv
// Single write port, registered read port RAM of float_24_8 words.
// Memory contents are never reset; only the read register is cleared.
module full_feed_ram
  import full_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  float_24_8     wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output float_24_8     rdata
);

  float_24_8 mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; holds its value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/full_feed.sv
// Streams training frames from a data RAM and per-frame targets from an
// expected RAM over two independent valid/ready channels.
// Optional macro FULL_FEED_LOOP_EN: loop over the frames until stop is seen.
module full_feed
  import full_feed_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned DEPTH     = 64,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned EDEPTH   = DEPTH / FRAME_LEN,
  localparam int unsigned EAW      = (EDEPTH > 1) ? $clog2(EDEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  float_24_8            wr_data,
  input  logic                 exp_wr_en,
  input  logic [EAW-1:0]       exp_wr_addr,
  input  float_24_8            exp_wr_data,
  input  logic                 start,
  input  logic [FrameCntW-1:0] num_frames,
  input  logic                 stop,
  output float_24_8            st_data,
  output logic                 st_data_fst,
  output logic                 st_data_vld,
  input  logic                 st_data_rdy,
  output float_24_8            expected,
  output logic                 expected_fst,
  output logic                 expected_vld,
  input  logic                 expected_rdy,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  full_feed_state_e       state_q, state_d;
  logic [FrameCntW-1:0]   nf_q, nf_d;
  logic                   d_vld_q, d_vld_d, d_done_q, d_done_d;
  logic [FrameCntW-1:0]   d_frame_q, d_frame_d;
  logic [WW-1:0]          d_word_q, d_word_d;
  logic                   e_vld_q, e_vld_d;
  logic [FrameCntW-1:0]   e_frame_q, e_frame_d, e_frame_adv;
  // Frames whose word 0 has been read but whose expected word has not.
  logic [FrameCntW:0]     credit_q, credit_d;
  logic [FrameCntW:0]     d_frame_inc;
  logic                   d_re, e_re, d_xfer, e_xfer, word0_issue, stop_eff;
  logic [AW-1:0]          d_raddr;
  logic [EAW-1:0]         e_raddr;
  logic                   idle;

`ifdef FULL_FEED_LOOP_EN
  localparam bit LoopEn = 1'b1;
  logic stop_q;

  // Remember a stop request until the current frame has completed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= (state_q == StRun) && (stop_q || stop);
    end
  end

  assign stop_eff = stop_q | stop;
`else
  localparam bit LoopEn = 1'b0;
  logic unused_stop;

  assign unused_stop = stop;
  assign stop_eff    = 1'b0;
`endif

  assign idle   = (state_q == StIdle);
  assign d_xfer = d_vld_q & st_data_rdy;
  assign e_xfer = e_vld_q & expected_rdy;

  // Next-state, read issue and channel bookkeeping.
  always_comb begin
    state_d     = state_q;
    nf_d        = nf_q;
    d_vld_d     = d_vld_q;
    d_done_d    = d_done_q;
    d_frame_d   = d_frame_q;
    d_word_d    = d_word_q;
    e_vld_d     = e_vld_q;
    e_frame_d   = e_frame_q;
    credit_d    = credit_q;
    d_re        = 1'b0;
    e_re        = 1'b0;
    word0_issue = 1'b0;
    d_frame_inc = {1'b0, d_frame_q} + 1'b1;
    e_frame_adv = (LoopEn && (({1'b0, e_frame_q} + 1'b1) == {1'b0, nf_q})) ? '0
                                                                           : e_frame_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          nf_d    = num_frames;
        end
      end
      StLoad: begin
        d_frame_d = '0;
        d_word_d  = '0;
        e_frame_d = '0;
        credit_d  = '0;
        d_done_d  = 1'b0;
        if (nf_q == '0) begin
          state_d = StFinish;
        end else begin
          d_re    = 1'b1;
          d_vld_d = 1'b1;
          e_re    = 1'b1;
          e_vld_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (d_xfer) begin
          if (d_word_q == WW'(FRAME_LEN - 1)) begin
            if (stop_eff || (!LoopEn && d_frame_inc == {1'b0, nf_q})) begin
              d_vld_d  = 1'b0;
              d_done_d = 1'b1;
            end else begin
              d_re        = 1'b1;
              word0_issue = 1'b1;
              d_word_d    = '0;
              d_frame_d   = (d_frame_inc == {1'b0, nf_q}) ? '0 : d_frame_inc[FrameCntW-1:0];
            end
          end else begin
            d_re     = 1'b1;
            d_word_d = d_word_q + 1'b1;
          end
        end
        if (e_xfer) begin
          e_vld_d   = 1'b0;
          e_frame_d = e_frame_adv;
        end
        // An expected word may only follow the data word 0 of its own frame.
        if ((!e_vld_q || e_xfer) && (credit_q != '0 || word0_issue)) begin
          e_re    = 1'b1;
          e_vld_d = 1'b1;
        end
        credit_d = credit_q + {{FrameCntW{1'b0}}, word0_issue} - {{FrameCntW{1'b0}}, e_re};
        if (d_done_d && !e_vld_d && credit_d == '0) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      nf_q      <= '0;
      d_vld_q   <= 1'b0;
      d_done_q  <= 1'b0;
      d_frame_q <= '0;
      d_word_q  <= '0;
      e_vld_q   <= 1'b0;
      e_frame_q <= '0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      nf_q      <= nf_d;
      d_vld_q   <= d_vld_d;
      d_done_q  <= d_done_d;
      d_frame_q <= d_frame_d;
      d_word_q  <= d_word_d;
      e_vld_q   <= e_vld_d;
      e_frame_q <= e_frame_d;
      credit_q  <= credit_d;
    end
  end

  // Truncation to AW bits gives the wrap modulo DEPTH.
  assign d_raddr = AW'(32'(d_frame_d) * FRAME_LEN + 32'(d_word_d));
  assign e_raddr = EAW'(32'(e_frame_d) % EDEPTH);

  full_feed_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en & idle),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (d_re),
    .raddr (d_raddr),
    .rdata (st_data)
  );

  full_feed_ram #(
    .DEPTH (EDEPTH),
    .AW    (EAW)
  ) u_exp_ram (
    .clk   (clk),
    .reset (reset),
    .we    (exp_wr_en & idle),
    .waddr (exp_wr_addr),
    .wdata (exp_wr_data),
    .re    (e_re),
    .raddr (e_raddr),
    .rdata (expected)
  );

  assign st_data_vld  = d_vld_q;
  assign st_data_fst  = d_vld_q & (d_word_q == '0);
  assign expected_vld = e_vld_q;
  assign expected_fst = e_vld_q;
  assign busy         = !idle;
  assign done         = (state_q == StFinish);

endmodule

// File: tb/tb_full_feed.sv
// Scoreboard bench for full_feed: expected words are queued when a run is
// launched and compared as each channel transfers.
module tb_full_feed;

  localparam int FL  = 4;
  localparam int DP  = 64;
  localparam int EDP = DP / FL;

  logic        clk = 1'b0;
  logic        reset, wr_en, exp_wr_en, start, stop, st_data_rdy, expected_rdy;
  logic [5:0]  wr_addr;
  logic [3:0]  exp_wr_addr;
  logic [31:0] wr_data, exp_wr_data, st_data, expected;
  logic [15:0] num_frames;
  logic        st_data_fst, st_data_vld, expected_fst, expected_vld, busy, done;

  always #5 clk = ~clk;

  full_feed #(
    .FRAME_LEN (FL),
    .DEPTH     (DP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .exp_wr_en    (exp_wr_en),
    .exp_wr_addr  (exp_wr_addr),
    .exp_wr_data  (exp_wr_data),
    .start        (start),
    .num_frames   (num_frames),
    .stop         (stop),
    .st_data      (st_data),
    .st_data_fst  (st_data_fst),
    .st_data_vld  (st_data_vld),
    .st_data_rdy  (st_data_rdy),
    .expected     (expected),
    .expected_fst (expected_fst),
    .expected_vld (expected_vld),
    .expected_rdy (expected_rdy),
    .busy         (busy),
    .done         (done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] dmem [DP];
  logic [31:0] emem [EDP];
  logic [32:0] d_q [$];
  logic [32:0] e_q [$];
  int          first_vld, first_evld, last_xfer, done_cyc, done_cnt, d_cnt, e_cnt;
  bit          rnd_rdy = 1'b0;
  bit          d_stall = 1'b0;
  bit          e_stall = 1'b0;
  logic [32:0] d_held, e_held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready, optionally with random gaps.
  always @(posedge clk) begin
    #1;
    st_data_rdy  = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    expected_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: transfers, stall stability, timing marks.
  always @(negedge clk) begin
    if (!reset) begin
      d_stall = 1'b0;
      e_stall = 1'b0;
    end else begin
      if (d_stall) check("d_hold", {st_data_vld, st_data_fst, st_data}, {1'b1, d_held});
      if (e_stall) check("e_hold", {expected_vld, expected_fst, expected}, {1'b1, e_held});
      if (st_data_vld && first_vld < 0) first_vld = cyc;
      if (expected_vld && first_evld < 0) first_evld = cyc;
      if (st_data_vld && st_data_rdy) begin
        if (d_q.size() != 0) check("d_word", {st_data_fst, st_data}, d_q.pop_front());
        d_cnt++;
        last_xfer = cyc;
      end
      if (expected_vld && expected_rdy) begin
        if (e_q.size() != 0) check("e_word", {expected_fst, expected}, e_q.pop_front());
        e_cnt++;
        last_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      d_stall = st_data_vld && !st_data_rdy;
      d_held  = {st_data_fst, st_data};
      e_stall = expected_vld && !expected_rdy;
      e_held  = {expected_fst, expected};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    first_vld  = -1;
    first_evld = -1;
    last_xfer  = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    d_cnt      = 0;
    e_cnt      = 0;
  endtask

  task automatic push_frames(input int nf, input int count);
    for (int k = 0; k < count; k++) begin
      int f;
      f = k % nf;
      for (int i = 0; i < FL; i++) d_q.push_back({(i == 0), dmem[(f * FL + i) % DP]});
      e_q.push_back({1'b1, emem[f % EDP]});
    end
  endtask

  task automatic run(input int nf, input int count, input bit rnd, input int stop_after,
                     input bit poke, input string tag);
    int t0;
    bit stopped;
    clear_stats();
    push_frames(nf, count);
    rnd_rdy = rnd;
    check({tag, "_idle_busy"}, busy, 0);
    num_frames = 16'(nf);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    stopped = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      if (poke && i == 2) begin
        start = 1'b1;
        num_frames = 16'd5;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = ~dmem[0];
      end else if (poke && i == 3) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (stop_after > 0 && !stopped && d_cnt >= stop_after) begin
        stop = 1'b1;
        stopped = 1'b1;
      end else begin
        stop = 1'b0;
      end
      tick();
    end
    stop = 1'b0;
    repeat (6) tick();
    rnd_rdy = 1'b0;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_d_cnt"}, d_cnt, count * FL);
    check({tag, "_e_cnt"}, e_cnt, count);
    check({tag, "_left"}, d_q.size() + e_q.size(), 0);
    if (count > 0) begin
      check({tag, "_first_vld"}, first_vld, t0 + 2);
      check({tag, "_first_evld"}, first_evld, t0 + 2);
      check({tag, "_done_at"}, done_cyc, last_xfer + 1);
    end else begin
      check({tag, "_no_vld"}, {first_vld, first_evld}, {32'hffff_ffff, 32'hffff_ffff});
      check({tag, "_done_at"}, done_cyc, t0 + 2);
    end
    d_q.delete();
    e_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    exp_wr_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    num_frames = '0;
    wr_addr = '0;
    wr_data = '0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    clear_stats();
    repeat (3) tick();
    check("rst_ctl", {st_data_vld, st_data_fst, expected_vld, expected_fst, busy, done}, 0);
    check("rst_data", {st_data, expected}, 0);
    reset = 1'b1;
    tick();

    for (int a = 0; a < DP; a++) begin
      dmem[a] = $urandom;
      wr_en = 1'b1;
      wr_addr = 6'(a);
      wr_data = dmem[a];
      tick();
    end
    wr_en = 1'b0;
    for (int a = 0; a < EDP; a++) begin
      emem[a] = $urandom;
      exp_wr_en = 1'b1;
      exp_wr_addr = 4'(a);
      exp_wr_data = emem[a];
      tick();
    end
    exp_wr_en = 1'b0;
    tick();

    run(2, 2, 1'b0, 0, 1'b0, "basic");
    run(2, 2, 1'b1, 0, 1'b0, "stall");
    run(20, 20, 1'b1, 0, 1'b0, "wrap");
    run(0, 0, 1'b0, 0, 1'b0, "zero");
    run(3, 3, 1'b0, 0, 1'b1, "busy_ign");
    run(1, 1, 1'b0, 0, 1'b0, "orig0");

    // A write in IDLE takes effect on the next run.
    dmem[0] = 32'h1234_5678;
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = dmem[0];
    tick();
    wr_en = 1'b0;
    run(1, 1, 1'b1, 0, 1'b0, "new0");

    // Reset in the middle of frame 1.
    clear_stats();
    push_frames(2, 2);
    num_frames = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && d_cnt < 5; i++) tick();
    check("rst_reach", d_cnt, 5);
    reset = 1'b0;
    d_q.delete();
    e_q.delete();
    tick();
    tick();
    check("mid_rst_ctl", {st_data_vld, st_data_fst, expected_vld, expected_fst, busy, done}, 0);
    check("mid_rst_data", {st_data, expected}, 0);
    reset = 1'b1;
    repeat (4) tick();
    check("mid_rst_no_done", done_cnt, 0);
    run(1, 1, 1'b0, 0, 1'b0, "restart");

`ifdef FULL_FEED_LOOP_EN
    run(2, 4, 1'b0, 13, 1'b0, "loop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
